// File: rtl/xor_cipher_cfg_loader_if.sv
// Host/cipher-side bundle for the XOR cipher config-chain loader.
//   wr_en/wr_data : bytewise seed write
//   start/verify  : kick off a load (optionally followed by a verify pass)
//   rd_en/rd_data : bytewise readback of bits captured from the chain
//   cfg_en/cfg_do : shift enable and serial data toward the cipher chain
//   cfg_di        : serial data returning from the cipher chain
//   busy/done/match : sequence status
// master = host + cipher side, slave = loader.
interface xor_cipher_cfg_loader_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic       verify;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       cfg_en;
  logic       cfg_do;
  logic       cfg_di;
  logic       busy;
  logic       done;
  logic       match;

  modport master (
    output wr_en, wr_data, start, verify, rd_en, cfg_di,
    input  rd_data, cfg_en, cfg_do, busy, done, match
  );

  modport slave (
    input  wr_en, wr_data, start, verify, rd_en, cfg_di,
    output rd_data, cfg_en, cfg_do, busy, done, match
  );
endinterface

// File: rtl/xor_cipher_cfg_loader.sv
// Serial config-chain initiator for the dual XOR stream cipher.
// The host writes an M-bit seed bytewise, then start shifts it MSB-first into
// the cipher chain while the bits falling out of the chain are captured for
// bytewise readback. With verify=1 a second identical pass follows and the
// returned bits are compared against the seed.
// Ports: clk, rst_n (async, active low), bus (slave modport, see interface).
module xor_cipher_cfg_loader #(
  parameter  int M  = 32,
  localparam int CW = $clog2(M)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  xor_cipher_cfg_loader_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t         state, state_nxt;
  logic [M-1:0]   seed, sh, cap;
  logic [CW-1:0]  cnt;
  logic           vmode;
  logic           match_q;

  logic           last;
  logic [M-1:0]   cap_in;
  logic [M-1:0]   seed_push;
  logic [M-1:0]   cap_pop;
  logic           cfg_en_o, busy_o, done_o;

  assign last      = (cnt == CW'(M-1));
  assign cap_in    = {cap[M-2:0], bus.cfg_di};
  // Shift form keeps both valid for the minimum chain length M=8.
  assign seed_push = (seed << 8) | M'(bus.wr_data);
  assign cap_pop   = cap << 8;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (last)      state_nxt = vmode ? VERIFY : DONE;
      VERIFY:  if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_en_o = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      LOAD, VERIFY: begin
        cfg_en_o = 1'b1;
        busy_o   = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: seed, rotating shifter, capture, counter, verify result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed    <= '0;
      sh      <= '0;
      cap     <= '0;
      cnt     <= '0;
      vmode   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // start wins over a same-cycle write
            sh      <= seed;
            cnt     <= '0;
            vmode   <= bus.verify;
            match_q <= 1'b0;
            cap     <= '0;
          end else begin
            if (bus.wr_en) seed <= seed_push;
            if (bus.rd_en) cap  <= cap_pop;
          end
        end
        LOAD, VERIFY: begin
          // Rotate so the seed is back in place after M shifts, ready for verify.
          sh  <= {sh[M-2:0], sh[M-1]};
          cap <= cap_in;
          cnt <= last ? '0 : cnt + CW'(1);
          if (state == VERIFY && last) match_q <= (cap_in == seed);
        end
        DONE: begin
          if (bus.wr_en) seed <= seed_push;
          if (bus.rd_en) cap  <= cap_pop;
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_en  = cfg_en_o;
  assign bus.busy    = busy_o;
  assign bus.done    = done_o;
  assign bus.cfg_do  = sh[M-1];
  assign bus.match   = match_q;
  assign bus.rd_data = cap[M-1:M-8];

endmodule

// File: tb/tb_xor_cipher_cfg_loader.sv
// Bench for xor_cipher_cfg_loader (M=32). The cipher chain is modelled as a
// 32-bit shift register; expectations come from the block's rules: after a
// load the chain holds the seed, capture holds the previous chain (or, after
// verify, what the chain returned), match is whether the chain still held the
// seed when the verify pass started.
module tb_xor_cipher_cfg_loader;
  localparam int M = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_cipher_cfg_loader_if bus();

  xor_cipher_cfg_loader #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Cipher chain model
  logic [31:0] chain = '0;
  logic [31:0] preload_val = '0;
  logic        preload_req = 1'b0;
  bit          flip7 = 1'b0;
  int          shifts = 0;

  assign bus.cfg_di = chain[31];

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (preload_req) begin
      chain  <= preload_val;
      shifts <= 0;
    end else if (bus.cfg_en) begin
      nxt = {chain[30:0], bus.cfg_do};
      if (flip7 && shifts == 31) nxt[7] = ~nxt[7];
      chain  <= nxt;
      shifts <= shifts + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic clear_inputs();
    bus.wr_en = 0; bus.wr_data = 0; bus.start = 0; bus.verify = 0; bus.rd_en = 0;
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk); preload_val = v; preload_req = 1;
    @(negedge clk); preload_req = 0;
  endtask

  task automatic write_seed(input logic [31:0] s);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.wr_en = 1; bus.wr_data = s[31-8*i -: 8];
    end
    @(negedge clk); bus.wr_en = 0;
  endtask

  // Reads 4 bytes of capture, returns them and the byte visible afterwards.
  task automatic read_cap(output logic [31:0] v, output logic [7:0] tail);
    v = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v = {v[23:0], bus.rd_data};
      bus.rd_en = 1;
      @(negedge clk);
    end
    bus.rd_en = 0;
    tail = bus.rd_data;
  endtask

  // Issues start and watches until the cycle after done (bounded).
  // Cycle k=1 is the cycle after the start edge.
  task automatic run_load(input bit vm, input bit noise, input bit collide,
                          output int en_cyc, output int done_at,
                          output int done_cnt, output int en_at_done);
    en_cyc = 0; done_at = -1; done_cnt = 0; en_at_done = 0;
    @(negedge clk);
    bus.start = 1; bus.verify = vm;
    if (collide) begin bus.wr_en = 1; bus.wr_data = 8'($urandom); end
    @(negedge clk);
    clear_inputs();
    for (int k = 1; k < 300; k++) begin
      if (bus.cfg_en) en_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        if (bus.cfg_en) en_at_done = 1;
      end
      if (done_at >= 0 && k > done_at) break;
      if (noise && k >= 2 && k <= 20) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.verify  = 1'($urandom_range(0, 1));
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.wr_data = 8'($urandom);
        bus.rd_en   = 1'($urandom_range(0, 1));
      end else clear_inputs();
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.cfg_en, bus.busy, bus.done, bus.match, bus.rd_data} !== 12'h0) begin
      fails++; $display("FAIL reset_state: got %b want 0", {bus.cfg_en, bus.busy, bus.done, bus.match, bus.rd_data});
    end
    rst_n = 1;
    write_seed(32'h0BADF00D);
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    repeat (10) @(negedge clk);   // cycle 11: ten shifts done
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_midload_busy: got %b want 1", bus.busy); end
    rst_n = 0;
    #1;
    tests++;
    if ({bus.cfg_en, bus.busy} !== 2'b00) begin
      fails++; $display("FAIL reset_async_drop: cfg_en/busy got %b want 00", {bus.cfg_en, bus.busy});
    end
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.cfg_en, bus.busy, bus.done, bus.match} !== 4'b0000) begin
      fails++; $display("FAIL reset_release_idle: got %b want 0000", {bus.cfg_en, bus.busy, bus.done, bus.match});
    end
  endtask

  task automatic test_load_only();
    int en, da, dc, ead;
    write_seed(32'hA53C0FF0);
    run_load(0, 0, 0, en, da, dc, ead);
    tests++; if (en !== 32) begin fails++; $display("FAIL load_en_cycles: got %0d want 32", en); end
    tests++; if (da !== 33) begin fails++; $display("FAIL load_done_cycle: got %0d want 33", da); end
    tests++; if (dc !== 1 || ead !== 0) begin fails++; $display("FAIL load_done_pulse: len %0d en_at_done %0d want 1 0", dc, ead); end
    tests++; if (chain !== 32'hA53C0FF0) begin fails++; $display("FAIL load_chain: got %h want a53c0ff0", chain); end
    tests++; if (bus.match !== 1'b0) begin fails++; $display("FAIL load_match: got %b want 0", bus.match); end
  endtask

  task automatic test_readback();
    int en, da, dc, ead;
    logic [31:0] v; logic [7:0] t;
    preload(32'h12345678);
    write_seed(32'hA53C0FF0);
    run_load(0, 0, 0, en, da, dc, ead);
    read_cap(v, t);
    tests++; if (v !== 32'h12345678) begin fails++; $display("FAIL readback_bytes: got %h want 12345678", v); end
    tests++; if (t !== 8'h00) begin fails++; $display("FAIL readback_empty: got %h want 00", t); end
  endtask

  task automatic test_verify(input bit flip);
    int en, da, dc, ead;
    logic [31:0] v; logic [7:0] t;
    logic [31:0] exp_cap;
    exp_cap = flip ? (32'hDEADBEEF ^ 32'h80) : 32'hDEADBEEF;
    preload(32'h5A5A1234);
    flip7 = flip;
    write_seed(32'hDEADBEEF);
    run_load(1, 0, 0, en, da, dc, ead);
    flip7 = 0;
    tests++; if (en !== 64 || da !== 65) begin fails++; $display("FAIL verify_timing f%0d: en %0d done %0d want 64 65", flip, en, da); end
    tests++; if (bus.match !== !flip) begin fails++; $display("FAIL verify_match f%0d: got %b want %b", flip, bus.match, !flip); end
    tests++; if (chain !== 32'hDEADBEEF) begin fails++; $display("FAIL verify_chain f%0d: got %h want deadbeef", flip, chain); end
    read_cap(v, t);
    tests++; if (v !== exp_cap) begin fails++; $display("FAIL verify_cap f%0d: got %h want %h", flip, v, exp_cap); end
    tests++; if (bus.match !== !flip) begin fails++; $display("FAIL verify_match_held f%0d: got %b want %b", flip, bus.match, !flip); end
  endtask

  task automatic test_collisions();
    int en, da, dc, ead;
    logic [31:0] v; logic [7:0] t;
    preload(32'hCAFE0001);
    write_seed(32'h13579BDF);
    run_load(0, 1, 1, en, da, dc, ead);
    tests++; if (en !== 32 || da !== 33) begin fails++; $display("FAIL collide_timing: en %0d done %0d want 32 33", en, da); end
    tests++; if (chain !== 32'h13579BDF) begin fails++; $display("FAIL collide_chain: got %h want 13579bdf", chain); end
    read_cap(v, t);
    tests++; if (v !== 32'hCAFE0001) begin fails++; $display("FAIL collide_cap: got %h want cafe0001", v); end
    // Rerun without writing: seed must have survived both collisions.
    preload(32'h0);
    run_load(0, 0, 0, en, da, dc, ead);
    tests++; if (chain !== 32'h13579BDF) begin fails++; $display("FAIL collide_seed_kept: got %h want 13579bdf", chain); end
  endtask

  task automatic test_random();
    int en, da, dc, ead;
    logic [31:0] v, prior, seed, exp_cap; logic [7:0] t;
    bit vm, fl;
    for (int it = 0; it < 6; it++) begin
      prior = $urandom; seed = $urandom;
      vm = 1'($urandom_range(0, 1)); fl = vm & 1'($urandom_range(0, 1));
      exp_cap = !vm ? prior : (fl ? seed ^ 32'h80 : seed);
      preload(prior);
      flip7 = fl;
      write_seed(seed);
      run_load(vm, 0, 0, en, da, dc, ead);
      flip7 = 0;
      tests++;
      if (en !== (vm ? 64 : 32) || da !== en + 1 || dc !== 1) begin
        fails++; $display("FAIL rand%0d_timing: en %0d done %0d len %0d vm %0d", it, en, da, dc, vm);
      end
      tests++; if (chain !== seed) begin fails++; $display("FAIL rand%0d_chain: got %h want %h", it, chain, seed); end
      tests++; if (bus.match !== (vm && !fl)) begin fails++; $display("FAIL rand%0d_match: got %b want %b", it, bus.match, vm && !fl); end
      read_cap(v, t);
      tests++; if (v !== exp_cap || t !== 8'h00) begin fails++; $display("FAIL rand%0d_cap: got %h/%h want %h/00", it, v, t, exp_cap); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_only();
    test_readback();
    test_verify(0);
    test_verify(1);
    test_collisions();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
